beta_uart_tx_mmio: RTL and testbench
====================================

Name: beta_uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the Beta data port, downstream of the CPU. It consumes DataAddress, DataWrite, WriteEnable and ReadEnable, and returns DataRead combinationally in the same cycle, because Beta loads are single-cycle. Bytes written by software are buffered in a TX FIFO and serialised as 8N1 frames. A completion interrupt feeds Beta's irq input.

Parameters:
BASE_ADDR, 32'hFFFF_FF00, register block base; 16-byte aligned (bits [3:0] = 0).
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock
rst  in  1  reset
addr  in  32  byte address (Beta DataAddress)
wdata  in  32  write data (Beta DataWrite)
we  in  1  write strobe (Beta WriteEnable)
re  in  1  read strobe (Beta ReadEnable)
rdata  out  32  read data, combinational
sel  out  1  address hit; lets the top-level mux choose rdata over RAM
tx  out  1  serial line, idle high
irq  out  1  interrupt request, level, registered

Behaviour:
- Reset: rst is synchronous and active-high on clock clk. After the reset edge:
  - tx=1, irq=0;
  - FIFO empty (count=0), FSM=IDLE;
  - ctrl.irq_en=0, pending=0, overflow=0.
  - Reset mid-frame aborts the frame; tx is high after the edge.
- Decode:
  - sel = (addr[31:4]==BASE_ADDR[31:4]).
  - Offset = addr[3:2]. addr[1:0] are ignored.
  - Writes act only when sel & we. rdata = 0 unless sel & re.
- Registers:
  - off0 TXDATA.
    - Write pushes wdata[7:0].
    - Read returns 0.
  - off1 STATUS (read):
    - bit0 full, bit1 empty, bit2 busy (FSM != IDLE), bit3 pending, bit4 overflow;
    - bits[11:8] count (zero-extended); other bits 0.
    - Writes are W1C: wdata[3] clears pending, wdata[4] clears overflow.
  - off2 CTRL:
    - bit0 irq_en, read/write; other bits read 0.
  - off3 reserved: reads 0, writes ignored.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo FIFO_DEPTH.
  - Full/empty use count (0..FIFO_DEPTH).
  - A push while full is dropped and sets overflow. This holds even if a pop happens the same edge; full is evaluated pre-edge.
  - Push and pop on the same edge when not full: count unchanged, both take effect.
- FSM states: IDLE, START, DATA, STOP. A bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) drive the timing.
  - IDLE: tx=1. If FIFO not empty, pop into the shift register and go to START.
    - Latency: write at edge N → count=1 after N → pop at N+1 → tx=0 after N+1.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: tx=shift[0], LSB first, for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit 7 → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last stop cycle:
    - FIFO not empty: pop and go directly to START (no idle gap).
    - FIFO empty: go to IDLE and set pending.
  - tx is a registered output: no glitches, exact CLKS_PER_BIT-cycle bit periods.
- Frame time: exactly 10*CLKS_PER_BIT cycles, start-bit edge to next start-bit edge, when back-to-back.
- Interrupt:
  - irq (registered) = pending & irq_en.
  - If a set of pending and a W1C clear of pending land on the same edge, the set wins.
  - Setting irq_en while pending=1 raises irq on the next edge.
- Reads have no side effects.

Test Plan:
1. Reset, then CLKS_PER_BIT=4, write 0x55 to TXDATA.
   - tx low from the edge after the pop for 4 cycles.
   - Then bits 1,0,1,0,1,0,1,0, 4 cycles each.
   - Then high 4 cycles; STATUS busy=0, empty=1, pending=1.
2. irq_en=1, write 0xA3 and wait for the frame end.
   - irq=1 one edge after pending sets.
   - Write STATUS 0x8: pending and irq drop to 0 on the next edges.
3. FIFO_DEPTH=8: write 10 bytes in 10 consecutive cycles.
   - The first is popped at once; 8 are buffered; the tenth is dropped.
   - STATUS full=1, overflow=1. All 9 frames transmit back-to-back, 40 cycles each, with no idle gap.
4. Read STATUS/CTRL/off3 with re=1 at BASE_ADDR+4/+8/+0xC.
   - Correct combinational values, 0 for off3.
   - An address outside the block gives sel=0 and rdata=0. we to a non-matching address leaves the FIFO untouched.
5. Assert rst during DATA bit 3 of a frame with 2 bytes queued.
   - After the edge: tx=1, STATUS empty=1, busy=0, irq=0. No further frames.
6. Write TXDATA in the same cycle STOP pops a queued byte with the FIFO full.
   - The write is dropped, overflow=1, count stays at FIFO_DEPTH-1.

Source files
------------

// File: rtl/beta_uart_tx_mmio_if.sv
// Beta data-port bus as seen by a memory-mapped peripheral.
// The CPU side is the master; the peripheral answers with rdata/sel in the same cycle.
interface beta_uart_tx_mmio_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        sel;

  modport master (output addr, wdata, we, re, input rdata, sel);
  modport slave  (input addr, wdata, we, re, output rdata, sel);
endinterface

// File: rtl/beta_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter for the Beta data port.
// Software pushes bytes into a TX FIFO; a completion interrupt fires when the FIFO drains.
module beta_uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  beta_uart_tx_mmio_if.slave   bus,
  output logic                 tx,
  output logic                 irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          irq_en, pending, overflow;

  logic [1:0]  off;
  logic        wr, push_req, push, pop, full, empty, bit_last;
  logic        set_pend, clr_pend, clr_ovf;
  logic [3:0]  cnt4;
  logic [31:0] status;

  assign off      = bus.addr[3:2];
  assign bus.sel  = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign wr       = bus.sel & bus.we;
  assign push_req = wr && (off == 2'd0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push     = push_req & ~full;
  assign bit_last = (bit_cnt == CW'(CLKS_PER_BIT - 1));
  // The FSM consumes a byte either from IDLE or on the last stop cycle (no idle gap).
  assign pop      = ~empty & ((state == IDLE) | ((state == STOP) & bit_last));
  assign set_pend = (state == STOP) & bit_last & empty;
  assign clr_pend = wr && (off == 2'd1) && bus.wdata[3];
  assign clr_ovf  = wr && (off == 2'd1) && bus.wdata[4];

  assign cnt4   = 4'(count);
  assign status = {20'h0, cnt4, 3'b000, overflow, pending, (state != IDLE), empty, full};

  always_comb begin
    bus.rdata = '0;
    if (bus.sel && bus.re) begin
      case (off)
        2'd1:    bus.rdata = status;
        2'd2:    bus.rdata = {31'h0, irq_en};
        default: bus.rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Set beats a same-edge W1C clear for both sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en   <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      pending  <= set_pend | (pending & ~clr_pend);
      overflow <= (push_req & full) | (overflow & ~clr_ovf);
      if (wr && (off == 2'd2)) irq_en <= bus.wdata[0];
      irq <= pending & irq_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift   <= mem[rd_ptr];
            tx      <= 1'b0;
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (bit_last) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else bit_cnt <= bit_cnt + CW'(1);
        end
        DATA: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shift[1];
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else bit_cnt <= bit_cnt + CW'(1);
        end
        STOP: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (!empty) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else state <= IDLE;
          end else bit_cnt <= bit_cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_beta_uart_tx_mmio.sv
// Bench for beta_uart_tx_mmio: a scoreboard of queued bytes is checked bit-by-bit
// against the serial line, sampled on every falling clock edge.
module tb_beta_uart_tx_mmio;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hFFFF_FF00;

  logic clk, rst, tx, irq;
  beta_uart_tx_mmio_if bus();

  beta_uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] sb[$];
  int         starts[$];
  bit         mon_active = 1'b0;
  int         mon_pos = 0;
  logic [7:0] mon_byte;

  // Scoreboard side: a low tx in idle starts a frame for the oldest queued byte.
  task automatic mon_step();
    int   k;
    logic e;
    if (rst) begin
      mon_active = 1'b0;
      return;
    end
    if (!mon_active) begin
      if (tx === 1'b0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: tx=%b at cycle %0d, expected idle 1", tx, cyc);
        end else begin
          mon_byte   = sb.pop_front();
          mon_active = 1'b1;
          mon_pos    = 1;
          starts.push_back(cyc);
        end
      end
    end else begin
      k = mon_pos / CPB;
      if (k == 0)      e = 1'b0;
      else if (k == 9) e = 1'b1;
      else             e = mon_byte[k-1];
      checks++;
      if (tx !== e) begin
        errors++;
        $display("FAIL frame_bit: byte %h pos %0d tx=%b expected %b", mon_byte, mon_pos, tx, e);
      end
      mon_pos++;
      if (mon_pos == 10 * CPB) mon_active = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    mon_step();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] b);
    bus_write(BASE, {24'h0, b});
    sb.push_back(b);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic s);
    bus.addr = a;
    bus.re   = 1'b1;
    #1;
    d = bus.rdata;
    s = bus.sel;
    bus.re = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || mon_active) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0 || mon_active) begin
      errors++;
      $display("FAIL wait_idle: %0d bytes still queued after %0d cycles, expected 0", sb.size(), budget);
    end
  endtask

  task automatic wait_cycle(input int target);
    int n = 0;
    while (cyc < target && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (cyc != target) begin
      errors++;
      $display("FAIL wait_cycle: reached cycle %0d, expected %0d", cyc, target);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic s;
    rst = 1'b1;
    bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    bus_read(BASE + 32'h4, d, s);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected 00000002", d); end
    bus_read(BASE + 32'h8, d, s);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000000", d); end
  endtask

  task automatic test_single_frame();
    logic [31:0] d; logic s;
    tx_write(8'h55);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL latency_pre: tx=%b expected 1", tx); end
    tick();
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL latency_start: tx=%b expected 0", tx); end
    wait_idle(200);
    tick();
    bus_read(BASE + 32'h4, d, s);
    checks++; if (d !== 32'h0A) begin errors++; $display("FAIL single_status: got %h expected 0000000a", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq: got %b expected 0", irq); end
  endtask

  task automatic test_irq();
    logic [31:0] d; logic s;
    bus_write(BASE + 32'h8, 32'h1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_en_same: got %b expected 0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_en_next: got %b expected 1", irq); end
    bus_write(BASE + 32'h4, 32'h8);
    bus_read(BASE + 32'h4, d, s);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL w1c_pending: got %h expected 00000002", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_lag: got %b expected 1", irq); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_drop: got %b expected 0", irq); end
    tx_write(8'hA3);
    wait_idle(200);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq); end
    tick();
    bus_read(BASE + 32'h4, d, s);
    checks++; if (d !== 32'h0A) begin errors++; $display("FAIL irq_pending: got %h expected 0000000a", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b expected 0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", irq); end
    bus_write(BASE + 32'h4, 32'h8);
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic s;
    starts.delete();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) tx_write(8'(i * 37 + 1));
      else       bus_write(BASE, 32'h0000_00FF);
    end
    bus_read(BASE + 32'h4, d, s);
    checks++; if (d !== 32'h815) begin errors++; $display("FAIL b2b_status: got %h expected 00000815", d); end
    wait_idle(600);
    checks++; if (starts.size() != 9) begin errors++; $display("FAIL b2b_frames: got %0d expected 9", starts.size()); end
    for (int i = 1; i < starts.size(); i++) begin
      checks++;
      if (starts[i] - starts[i-1] != 10 * CPB) begin
        errors++;
        $display("FAIL b2b_gap: frame %0d spacing %0d expected %0d", i, starts[i] - starts[i-1], 10 * CPB);
      end
    end
    tick();
    bus_write(BASE + 32'h4, 32'h18);
    bus_read(BASE + 32'h4, d, s);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL b2b_clear: got %h expected 00000002", d); end
  endtask

  task automatic test_decode();
    logic [31:0] d; logic s;
    bus_read(BASE + 32'h8, d, s);
    checks++; if (d !== 32'h1 || s !== 1'b1) begin errors++; $display("FAIL dec_ctrl: got %h sel %b expected 00000001 sel 1", d, s); end
    bus_read(BASE + 32'hC, d, s);
    checks++; if (d !== 32'h0 || s !== 1'b1) begin errors++; $display("FAIL dec_off3: got %h sel %b expected 00000000 sel 1", d, s); end
    bus_read(BASE, d, s);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL dec_txdata: got %h expected 00000000", d); end
    bus_read(BASE + 32'h6, d, s);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL dec_lowbits: got %h expected 00000002", d); end
    bus_read(BASE + 32'h10, d, s);
    checks++; if (d !== 32'h0 || s !== 1'b0) begin errors++; $display("FAIL dec_outside: got %h sel %b expected 00000000 sel 0", d, s); end
    bus.addr = BASE + 32'h4;
    #1;
    checks++; if (bus.rdata !== 32'h0 || bus.sel !== 1'b1) begin errors++; $display("FAIL dec_no_re: got %h sel %b expected 00000000 sel 1", bus.rdata, bus.sel); end
    bus_write(BASE + 32'h10, 32'h77);
    bus_write(32'hFFFF_FEF0, 32'h77);
    bus_write(BASE + 32'hC, 32'hFF);
    repeat (5) tick();
    bus_read(BASE + 32'h4, d, s);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL dec_miss_write: got %h expected 00000002", d); end
    bus_write(BASE + 32'h8, 32'hFFFF_FFFE);
    bus_read(BASE + 32'h8, d, s);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL dec_ctrl_clr: got %h expected 00000000", d); end
  endtask

  task automatic test_full_pop_collision();
    logic [31:0] d; logic s;
    starts.delete();
    for (int i = 0; i < 9; i++) tx_write(8'(8'hC0 + i));
    checks++;
    if (starts.size() == 0) begin
      errors++;
      $display("FAIL coll_start: frames started %0d expected 1", starts.size());
    end else begin
      // The next edge is the last stop cycle of the first frame, where it pops.
      wait_cycle(starts[0] + 10 * CPB - 1);
      bus_write(BASE, 32'hEE);
      bus_read(BASE + 32'h4, d, s);
      checks++; if (d !== 32'h714) begin errors++; $display("FAIL coll_status: got %h expected 00000714", d); end
    end
    wait_idle(600);
    checks++; if (starts.size() != 9) begin errors++; $display("FAIL coll_frames: got %0d expected 9", starts.size()); end
    tick();
    bus_write(BASE + 32'h4, 32'h18);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d; logic s;
    starts.delete();
    for (int i = 0; i < 3; i++) tx_write(8'(8'h3C + i));
    checks++;
    if (starts.size() == 0) begin
      errors++;
      $display("FAIL rst_start: frames started %0d expected 1", starts.size());
    end else begin
      wait_cycle(starts[0] + 4 * CPB + 1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b expected 1", tx); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq); end
    bus_read(BASE + 32'h4, d, s);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL rst_status: got %h expected 00000002", d); end
    repeat (100) tick();
    checks++; if (starts.size() != 1 || tx !== 1'b1) begin errors++; $display("FAIL rst_quiet: frames %0d tx %b expected 1 frame tx 1", starts.size(), tx); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_irq();
    test_back_to_back();
    test_decode();
    test_full_pop_collision();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
